// File: rtl/hazard_control_unit_mc_if.sv
// Hazard-controller bundle: pipeline-side register/branch/multi-cycle inputs and control outputs.
// No latency of its own; it only carries the signals.
// No flow control; every signal is a level sampled each cycle.
interface hazard_control_unit_mc_if #(
  parameter int REG_AW = 5,
  parameter int LAT_W  = 6,
  parameter int PERF_W = 32
);
  logic [REG_AW-1:0] RS1_D, RS2_D;
  logic [REG_AW-1:0] RS1_E, RS2_E, RD_E;
  logic [REG_AW-1:0] RD_M, RD_W;
  logic              Result_Src_Sel_E;
  logic              REG_W_En_M, REG_W_En_W;
  logic              Branch_Taken_E, Predict_Taken_E;
  logic              MC_Start_E;
  logic [LAT_W-1:0]  MC_Lat_E;
  logic              Perf_Clr;
  logic [1:0]        FWD_SrcA, FWD_SrcB;
  logic              Stall_F, Stall_D, Stall_E, PC_En;
  logic              Flush_D, Flush_E, Bubble_M;
  logic              MC_Busy;
  logic [PERF_W-1:0] Stall_Cycles, Mispredicts;

  // Pipeline side: drives stage information, consumes the control decisions.
  modport master (
    output RS1_D, RS2_D, RS1_E, RS2_E, RD_E, RD_M, RD_W, Result_Src_Sel_E,
           REG_W_En_M, REG_W_En_W, Branch_Taken_E, Predict_Taken_E,
           MC_Start_E, MC_Lat_E, Perf_Clr,
    input  FWD_SrcA, FWD_SrcB, Stall_F, Stall_D, Stall_E, PC_En,
           Flush_D, Flush_E, Bubble_M, MC_Busy, Stall_Cycles, Mispredicts
  );

  // Hazard unit side.
  modport slave (
    input  RS1_D, RS2_D, RS1_E, RS2_E, RD_E, RD_M, RD_W, Result_Src_Sel_E,
           REG_W_En_M, REG_W_En_W, Branch_Taken_E, Predict_Taken_E,
           MC_Start_E, MC_Lat_E, Perf_Clr,
    output FWD_SrcA, FWD_SrcB, Stall_F, Stall_D, Stall_E, PC_En,
           Flush_D, Flush_E, Bubble_M, MC_Busy, Stall_Cycles, Mispredicts
  );
endinterface

// File: rtl/hazard_control_unit_mc.sv
// RV32i hazard control: forwarding selects, load-use stall, mispredict flush, multi-cycle execute hold.
// Zero-cycle combinational outputs from inputs + registered FSM state; MC_Busy and counters registered.
// Holds the front end via Stall_F/D/E while a multi-cycle op occupies E; optional counters under HAZARD_PERF_CNT_EN.
module hazard_control_unit_mc #(
  parameter int REG_AW = 5,
  parameter int LAT_W  = 6,
  parameter int PERF_W = 32
) (
  input logic                  CLK,
  input logic                  RST,
  hazard_control_unit_mc_if.slave bus
);

  localparam logic [1:0] FWD_NONE = 2'b00;
  localparam logic [1:0] FWD_WB   = 2'b01;
  localparam logic [1:0] FWD_MEM  = 2'b10;

  localparam logic [LAT_W-1:0] LAT_ONE = LAT_W'(1);
  localparam logic [LAT_W-1:0] LAT_TWO = LAT_W'(2);

  typedef enum logic [1:0] {S_IDLE, S_BUSY, S_RELEASE} state_t;

  state_t            r_state, w_state_nxt;
  logic [LAT_W-1:0]  r_cnt, w_cnt_nxt;
  logic              r_mc_busy;
  logic              w_mc_hold;
  logic              w_lu, w_mp;
  logic [1:0]        w_fwd_a, w_fwd_b;
  logic              w_stall_f, w_stall_d, w_stall_e;
  logic              w_flush_d, w_flush_e, w_bubble_m;

  // Forwarding: memory stage is younger, so it wins over writeback; x0 is never forwarded.
  always_comb begin
    w_fwd_a = FWD_NONE;
    w_fwd_b = FWD_NONE;
    if (bus.REG_W_En_M && (bus.RD_M != '0) && (bus.RS1_E == bus.RD_M))
      w_fwd_a = FWD_MEM;
    else if (bus.REG_W_En_W && (bus.RD_W != '0) && (bus.RS1_E == bus.RD_W))
      w_fwd_a = FWD_WB;
    if (bus.REG_W_En_M && (bus.RD_M != '0) && (bus.RS2_E == bus.RD_M))
      w_fwd_b = FWD_MEM;
    else if (bus.REG_W_En_W && (bus.RD_W != '0) && (bus.RS2_E == bus.RD_W))
      w_fwd_b = FWD_WB;
  end

  assign w_lu = bus.Result_Src_Sel_E && (bus.RD_E != '0) &&
                ((bus.RS1_D == bus.RD_E) || (bus.RS2_D == bus.RD_E));
  assign w_mp = bus.Branch_Taken_E != bus.Predict_Taken_E;

  // Multi-cycle occupancy: hold while the op still needs E, release on its final cycle.
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_mc_hold   = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (bus.MC_Start_E && (bus.MC_Lat_E >= LAT_TWO)) begin
          w_mc_hold   = 1'b1;
          w_cnt_nxt   = bus.MC_Lat_E - LAT_TWO;
          w_state_nxt = (bus.MC_Lat_E == LAT_TWO) ? S_RELEASE : S_BUSY;
        end
      end
      S_BUSY: begin
        // BUSY is only entered with cnt >= 1, so this never wraps.
        w_mc_hold = 1'b1;
        w_cnt_nxt = r_cnt - LAT_ONE;
        if (r_cnt == LAT_ONE) w_state_nxt = S_RELEASE;
      end
      S_RELEASE: begin
        // MC_Start_E still belongs to the departing op here, so it is not looked at.
        w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // FSM state, counter and busy flag registers.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_state   <= S_IDLE;
      r_cnt     <= '0;
      r_mc_busy <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_cnt     <= w_cnt_nxt;
      r_mc_busy <= (w_state_nxt != S_IDLE);
    end
  end

  // Hazard priority: multi-cycle hold, then mispredict, then load-use.
  always_comb begin
    w_stall_f  = 1'b0;
    w_stall_d  = 1'b0;
    w_stall_e  = 1'b0;
    w_flush_d  = 1'b0;
    w_flush_e  = 1'b0;
    w_bubble_m = 1'b0;
    if (w_mc_hold) begin
      w_stall_f  = 1'b1;
      w_stall_d  = 1'b1;
      w_stall_e  = 1'b1;
      w_bubble_m = 1'b1;
    end else if (w_mp) begin
      w_flush_d = 1'b1;
      w_flush_e = 1'b1;
    end else if (w_lu) begin
      w_stall_f = 1'b1;
      w_stall_d = 1'b1;
      w_flush_e = 1'b1;
    end
  end

  assign bus.FWD_SrcA = w_fwd_a;
  assign bus.FWD_SrcB = w_fwd_b;
  assign bus.Stall_F  = w_stall_f;
  assign bus.Stall_D  = w_stall_d;
  assign bus.Stall_E  = w_stall_e;
  assign bus.PC_En    = ~w_stall_f;
  assign bus.Flush_D  = w_flush_d;
  assign bus.Flush_E  = w_flush_e;
  assign bus.Bubble_M = w_bubble_m;
  assign bus.MC_Busy  = r_mc_busy;

`ifdef HAZARD_PERF_CNT_EN
  localparam logic [PERF_W-1:0] PERF_ONE = PERF_W'(1);
  logic [PERF_W-1:0] r_stall_cycles, r_mispredicts;

  // Saturating hazard counters; clear takes priority over counting.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_stall_cycles <= '0;
      r_mispredicts  <= '0;
    end else if (bus.Perf_Clr) begin
      r_stall_cycles <= '0;
      r_mispredicts  <= '0;
    end else begin
      if (w_stall_d && (r_stall_cycles != '1))
        r_stall_cycles <= r_stall_cycles + PERF_ONE;
      if (w_mp && !w_mc_hold && (r_mispredicts != '1))
        r_mispredicts <= r_mispredicts + PERF_ONE;
    end
  end

  assign bus.Stall_Cycles = r_stall_cycles;
  assign bus.Mispredicts  = r_mispredicts;
`else
  logic w_unused_perf_clr;
  assign w_unused_perf_clr = bus.Perf_Clr;
  assign bus.Stall_Cycles  = '0;
  assign bus.Mispredicts   = '0;
`endif

endmodule

// File: tb/tb_hazard_control_unit_mc.sv
// Self-checking bench for hazard_control_unit_mc: forwarding, load-use, mispredict, multi-cycle FSM, reset, counters.
// Inputs driven 1 ns after the rising edge; outputs sampled on the falling edge or 1 ns after a change.
// Expected values are queued when stimulus is applied and popped when the DUT output is sampled.
module tb_hazard_control_unit_mc;

  localparam int REG_AW = 5;
  localparam int LAT_W  = 6;
  localparam int PERF_W = 32;

  // Control vector order: Stall_F Stall_D Stall_E PC_En Flush_D Flush_E Bubble_M
  localparam logic [6:0] C_NONE = 7'b0001000;
  localparam logic [6:0] C_LU   = 7'b1100010;
  localparam logic [6:0] C_MP   = 7'b0001110;
  localparam logic [6:0] C_MC   = 7'b1110001;

  logic CLK = 1'b0;
  logic RST = 1'b0;

  int n_cmp = 0;
  int n_bad = 0;

  logic [11:0]       sb_q[$];
  logic [2*PERF_W-1:0] sb_cnt_q[$];

  hazard_control_unit_mc_if #(.REG_AW(REG_AW), .LAT_W(LAT_W), .PERF_W(PERF_W)) bus ();

  hazard_control_unit_mc #(.REG_AW(REG_AW), .LAT_W(LAT_W), .PERF_W(PERF_W)) dut (
    .CLK (CLK),
    .RST (RST),
    .bus (bus)
  );

  always #5 CLK = ~CLK;

  // Packs {FWD_SrcA, FWD_SrcB, Stall_F, Stall_D, Stall_E, PC_En, Flush_D, Flush_E, Bubble_M, MC_Busy}.
  function automatic logic [11:0] obs();
    return {bus.FWD_SrcA, bus.FWD_SrcB, bus.Stall_F, bus.Stall_D, bus.Stall_E, bus.PC_En,
            bus.Flush_D, bus.Flush_E, bus.Bubble_M, bus.MC_Busy};
  endfunction

  task automatic clear_inputs();
    bus.RS1_D = '0; bus.RS2_D = '0; bus.RS1_E = '0; bus.RS2_E = '0;
    bus.RD_E = '0; bus.RD_M = '0; bus.RD_W = '0;
    bus.Result_Src_Sel_E = 1'b0; bus.REG_W_En_M = 1'b0; bus.REG_W_En_W = 1'b0;
    bus.Branch_Taken_E = 1'b0; bus.Predict_Taken_E = 1'b0;
    bus.MC_Start_E = 1'b0; bus.MC_Lat_E = '0; bus.Perf_Clr = 1'b0;
  endtask

  task automatic test_reset();
    logic [11:0] e, got;
    logic [2*PERF_W-1:0] ec, gc;
    clear_inputs();
    RST = 1'b1;
    #1;
    sb_q.push_back({2'b00, 2'b00, C_NONE, 1'b0});
    sb_cnt_q.push_back('0);
    @(posedge CLK); @(negedge CLK);
    e = sb_q.pop_front(); got = obs();
    n_cmp++;
    if (got !== e) begin n_bad++; $display("FAIL reset_outputs: got %b expected %b", got, e); end
    ec = sb_cnt_q.pop_front(); gc = {bus.Stall_Cycles, bus.Mispredicts};
    n_cmp++;
    if (gc !== ec) begin n_bad++; $display("FAIL reset_counters: got %h expected %h", gc, ec); end
    RST = 1'b0;
  endtask

  task automatic test_forwarding();
    // rs1e rs2e rdm enm rdw enw fwd_a fwd_b
    int tbl [6][8] = '{
      '{5, 0, 5, 1, 5, 1, 2, 0},
      '{5, 0, 0, 1, 5, 1, 1, 0},
      '{5, 5, 5, 0, 5, 1, 1, 1},
      '{7, 5, 5, 1, 7, 1, 1, 2},
      '{0, 0, 0, 1, 0, 1, 0, 0},
      '{9, 9, 3, 1, 4, 1, 0, 0}
    };
    logic [11:0] e, got;
    for (int i = 0; i < 6; i++) begin
      @(posedge CLK); #1;
      clear_inputs();
      bus.RS1_E = REG_AW'(tbl[i][0]); bus.RS2_E = REG_AW'(tbl[i][1]);
      bus.RD_M = REG_AW'(tbl[i][2]);  bus.REG_W_En_M = tbl[i][3][0];
      bus.RD_W = REG_AW'(tbl[i][4]);  bus.REG_W_En_W = tbl[i][5][0];
      sb_q.push_back({tbl[i][6][1:0], tbl[i][7][1:0], C_NONE, 1'b0});
      @(negedge CLK);
      e = sb_q.pop_front(); got = obs();
      n_cmp++;
      if (got !== e) begin n_bad++; $display("FAIL forwarding[%0d]: got %b expected %b", i, got, e); end
    end
  endtask

  task automatic test_load_use();
    // rsel rs1d rs2d rde
    int tbl [5][4] = '{
      '{0, 3, 0, 3},
      '{1, 3, 0, 3},
      '{1, 3, 0, 0},
      '{1, 0, 3, 3},
      '{1, 4, 5, 3}
    };
    logic [6:0] exp_c [5] = '{C_NONE, C_LU, C_NONE, C_LU, C_NONE};
    logic [11:0] e, got;
    for (int i = 0; i < 5; i++) begin
      @(posedge CLK); #1;
      clear_inputs();
      bus.Result_Src_Sel_E = tbl[i][0][0];
      bus.RS1_D = REG_AW'(tbl[i][1]); bus.RS2_D = REG_AW'(tbl[i][2]);
      bus.RD_E = REG_AW'(tbl[i][3]);
      sb_q.push_back({4'b0000, exp_c[i], 1'b0});
      @(negedge CLK);
      e = sb_q.pop_front(); got = obs();
      n_cmp++;
      if (got !== e) begin n_bad++; $display("FAIL load_use[%0d]: got %b expected %b", i, got, e); end
    end
  endtask

  task automatic test_mispredict();
    // taken predicted with_lu
    int tbl [4][3] = '{
      '{1, 0, 1},
      '{0, 1, 0},
      '{1, 1, 1},
      '{0, 0, 0}
    };
    logic [6:0] exp_c [4] = '{C_MP, C_MP, C_LU, C_NONE};
    logic [11:0] e, got;
    for (int i = 0; i < 4; i++) begin
      @(posedge CLK); #1;
      clear_inputs();
      bus.Branch_Taken_E = tbl[i][0][0]; bus.Predict_Taken_E = tbl[i][1][0];
      if (tbl[i][2] != 0) begin
        bus.Result_Src_Sel_E = 1'b1; bus.RS1_D = 5'd3; bus.RD_E = 5'd3;
      end
      sb_q.push_back({4'b0000, exp_c[i], 1'b0});
      @(negedge CLK);
      e = sb_q.pop_front(); got = obs();
      n_cmp++;
      if (got !== e) begin n_bad++; $display("FAIL mispredict[%0d]: got %b expected %b", i, got, e); end
    end
  endtask

  task automatic test_multicycle();
    int lats [4] = '{4, 1, 2, 3};
    logic [11:0] e, got;
    for (int j = 0; j < 4; j++) begin
      int lat = lats[j];
      int drop_k = (lat < 2) ? 1 : lat;
      for (int k = 0; k <= lat + 1; k++) begin
        logic st, by;
        @(posedge CLK); #1;
        clear_inputs();
        if (k < drop_k) begin
          bus.MC_Start_E = 1'b1; bus.MC_Lat_E = LAT_W'(lat);
        end
        // The lat=3 op shares its first cycle with a mispredict; the hold must win.
        if (lat == 3 && k == 0) begin
          bus.Branch_Taken_E = 1'b1; bus.Predict_Taken_E = 1'b0;
        end
        st = (lat >= 2) && (k <= lat - 2);
        by = (lat >= 2) && (k >= 1) && (k <= lat - 1);
        sb_q.push_back({4'b0000, st ? C_MC : C_NONE, by});
        @(negedge CLK);
        e = sb_q.pop_front(); got = obs();
        n_cmp++;
        if (got !== e) begin n_bad++; $display("FAIL multicycle_L%0d[t+%0d]: got %b expected %b", lat, k, got, e); end
      end
    end
  endtask

  task automatic test_back_to_back();
    // Two L=2 ops: Start stays high through the first op's RELEASE, then starts the second.
    logic [6:0] exp_c [5] = '{C_MC, C_NONE, C_MC, C_NONE, C_NONE};
    logic       exp_b [5] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
    logic [11:0] e, got;
    for (int k = 0; k < 5; k++) begin
      @(posedge CLK); #1;
      clear_inputs();
      if (k < 4) begin bus.MC_Start_E = 1'b1; bus.MC_Lat_E = LAT_W'(2); end
      sb_q.push_back({4'b0000, exp_c[k], exp_b[k]});
      @(negedge CLK);
      e = sb_q.pop_front(); got = obs();
      n_cmp++;
      if (got !== e) begin n_bad++; $display("FAIL back_to_back[%0d]: got %b expected %b", k, got, e); end
    end
  endtask

  task automatic test_reset_busy();
    logic [11:0] e, got;
    for (int k = 0; k < 4; k++) begin
      @(posedge CLK); #1;
      clear_inputs();
      if (k < 3) begin bus.MC_Start_E = 1'b1; bus.MC_Lat_E = LAT_W'(10); end
      sb_q.push_back({4'b0000, C_MC, (k >= 1)});
      @(negedge CLK);
      e = sb_q.pop_front(); got = obs();
      n_cmp++;
      if (got !== e) begin n_bad++; $display("FAIL rst_busy_pre[%0d]: got %b expected %b", k, got, e); end
    end
    // Mid-cycle asynchronous reset: stalls must fall before any clock edge.
    RST = 1'b1;
    sb_q.push_back({4'b0000, C_NONE, 1'b0});
    #1;
    e = sb_q.pop_front(); got = obs();
    n_cmp++;
    if (got !== e) begin n_bad++; $display("FAIL rst_busy_async: got %b expected %b", got, e); end
    #1 RST = 1'b0;
    @(posedge CLK); #1;
    sb_q.push_back({4'b0000, C_NONE, 1'b0});
    @(negedge CLK);
    e = sb_q.pop_front(); got = obs();
    n_cmp++;
    if (got !== e) begin n_bad++; $display("FAIL rst_busy_idle: got %b expected %b", got, e); end
  endtask

  task automatic test_perf();
    logic [2*PERF_W-1:0] ec, gc;
    @(posedge CLK); #1;
    clear_inputs();
    bus.Perf_Clr = 1'b1;
    @(posedge CLK); #1;
    bus.Perf_Clr = 1'b0;
    for (int i = 0; i < 3; i++) begin
      bus.Result_Src_Sel_E = 1'b1; bus.RS1_D = 5'd3; bus.RD_E = 5'd3;
      @(posedge CLK); #1;
    end
    clear_inputs();
    for (int i = 0; i < 2; i++) begin
      bus.Branch_Taken_E = 1'b1; bus.Predict_Taken_E = 1'b0;
      @(posedge CLK); #1;
    end
    clear_inputs();
`ifdef HAZARD_PERF_CNT_EN
    sb_cnt_q.push_back({PERF_W'(3), PERF_W'(2)});
`else
    sb_cnt_q.push_back('0);
`endif
    @(negedge CLK);
    ec = sb_cnt_q.pop_front(); gc = {bus.Stall_Cycles, bus.Mispredicts};
    n_cmp++;
    if (gc !== ec) begin n_bad++; $display("FAIL perf_counts: got %h expected %h", gc, ec); end
    // Clear together with a load-use: clear must win over the increment.
    @(posedge CLK); #1;
    bus.Perf_Clr = 1'b1;
    bus.Result_Src_Sel_E = 1'b1; bus.RS1_D = 5'd3; bus.RD_E = 5'd3;
    sb_cnt_q.push_back('0);
    @(posedge CLK); #1;
    clear_inputs();
    @(negedge CLK);
    ec = sb_cnt_q.pop_front(); gc = {bus.Stall_Cycles, bus.Mispredicts};
    n_cmp++;
    if (gc !== ec) begin n_bad++; $display("FAIL perf_clear: got %h expected %h", gc, ec); end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "watchdog expired");
  end

  initial begin
    clear_inputs();
    test_reset();
    test_forwarding();
    test_load_use();
    test_mispredict();
    test_multicycle();
    test_back_to_back();
    test_reset_busy();
    test_perf();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
